// File: rtl/alu_iter_if.sv
// Start/done operation bus between the execute-stage controller and alu_iter.
// The controller drives the operation request; the ALU returns result, flags and handshake.
interface alu_iter_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [2:0]       ALUop;
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic [WIDTH-1:0] out;
    logic [2:0]       status;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output ALUop,
        output Ain,
        output Bin,
        input  out,
        input  status,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  ALUop,
        input  Ain,
        input  Bin,
        output out,
        output status,
        output busy,
        output done
    );
endinterface

// File: rtl/alu_iter.sv
// Multi-cycle execute-stage ALU: single-cycle ADD/SUB/AND/NOT, iterative shift-add MUL and
// bit-serial LSL/ASR, with registered result, {V,N,Z} flags and a start/done handshake.
module alu_iter #(
    parameter int unsigned WIDTH = 16,
    localparam int unsigned SW = $clog2(WIDTH)
) (
    input logic       clk,
    input logic       reset,
    alu_iter_if.slave bus
);

    localparam int unsigned Msb = WIDTH - 1;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpNot = 3'b011;
    localparam logic [2:0] OpMul = 3'b100;
    localparam logic [2:0] OpLsl = 3'b101;
    localparam logic [2:0] OpAsr = 3'b110;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StShift
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [2:0]         status_q, status_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   single_res;
    logic               single_v;
    logic [SW-1:0]      shamt;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   shift_step;

    function automatic logic [2:0] flags(input logic v, input logic [WIDTH-1:0] r);
        return {v, r[WIDTH-1], (r == '0)};
    endfunction

    assign shamt = bus.Ain[SW-1:0];

    // Combinational result for the ops that complete in the start cycle.
    always_comb begin
        sum        = bus.Ain + bus.Bin;
        diff       = bus.Ain - bus.Bin;
        single_res = '0;
        single_v   = 1'b0;
        case (bus.ALUop)
            OpAdd: begin
                single_res = sum;
                single_v   = (bus.Ain[Msb] == bus.Bin[Msb]) && (sum[Msb] != bus.Ain[Msb]);
            end
            OpSub: begin
                single_res = diff;
                single_v   = (bus.Ain[Msb] != bus.Bin[Msb]) && (diff[Msb] != bus.Ain[Msb]);
            end
            OpAnd:   single_res = bus.Ain & bus.Bin;
            OpNot:   single_res = ~bus.Bin;
            default: single_res = '0;
        endcase
    end

    // One iteration step of the multiplier and the shifter.
    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        if (op_q == OpLsl) begin
            shift_step = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            shift_step = {shreg_q[Msb], shreg_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        shreg_d  = shreg_q;
        out_d    = out_q;
        status_d = status_q;
        done_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    op_d = bus.ALUop;
                    case (bus.ALUop)
                        OpMul: begin
                            mcand_d  = {{WIDTH{1'b0}}, bus.Ain};
                            mplier_d = bus.Bin;
                            acc_d    = '0;
                            cnt_d    = SW'(WIDTH - 1);
                            state_d  = StMul;
                        end
                        OpLsl, OpAsr: begin
                            if (shamt == '0) begin
                                out_d    = bus.Bin;
                                status_d = flags(1'b0, bus.Bin);
                                done_d   = 1'b1;
                            end else begin
                                // Count holds remaining steps minus one so both loops end on zero.
                                shreg_d = bus.Bin;
                                cnt_d   = shamt - 1'b1;
                                state_d = StShift;
                            end
                        end
                        default: begin
                            out_d    = single_res;
                            status_d = flags(single_v, single_res);
                            done_d   = 1'b1;
                        end
                    endcase
                end
            end

            StMul: begin
                acc_d    = acc_step;
                mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    out_d    = acc_step[WIDTH-1:0];
                    status_d = flags(|acc_step[2*WIDTH-1:WIDTH], acc_step[WIDTH-1:0]);
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
            end

            StShift: begin
                shreg_d = shift_step;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    out_d    = shift_step;
                    status_d = flags(1'b0, shift_step);
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= '0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            shreg_q  <= '0;
            out_q    <= '0;
            status_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            shreg_q  <= shreg_d;
            out_q    <= out_d;
            status_q <= status_d;
            done_q   <= done_d;
        end
    end

    assign bus.out    = out_q;
    assign bus.status = status_q;
    assign bus.done   = done_q;
    assign bus.busy   = (state_q != StIdle);

    busy_done_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(bus.busy && bus.done));

    result_held_between_done: assert property (@(posedge clk) disable iff (reset)
        (!bus.done && !$past(reset)) |-> ($stable(bus.out) && $stable(bus.status)));

endmodule

// File: tb/tb_alu_iter.sv
// Randomised scoreboard bench for alu_iter: an arithmetic reference model predicts result,
// flags and completion cycle; a negedge monitor checks every done pulse and the busy/hold behaviour.
module tb_alu_iter;
    localparam int unsigned W   = 16;
    localparam longint      Mod = 64'sd1 << W;

    typedef struct {
        logic [W-1:0] res;
        logic [2:0]   st;
        int           done_cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    alu_iter_if #(.WIDTH(W)) bus ();

    alu_iter #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    exp_t         sb[$];
    exp_t         mon_e;
    int           cyc        = 0;
    int           checks     = 0;
    int           errors     = 0;
    int           busy_start = 0;
    int           busy_end   = 0;
    logic [W-1:0] held_res   = '0;
    logic [2:0]   held_st    = '0;
    int           nb;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on wide integers, reduced mod 2^W.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] res,
                                  output logic [2:0] st, output int nbusy);
        longint sa, sbv, r, full;
        int     sh;
        logic   v;
        sa    = a[W-1] ? longint'(a) - Mod : longint'(a);
        sbv   = b[W-1] ? longint'(b) - Mod : longint'(b);
        sh    = int'(a) % W;
        v     = 1'b0;
        nbusy = 0;
        r     = 0;
        case (op)
            3'd0: begin r = sa + sbv; v = (r > Mod / 2 - 1) || (r < -(Mod / 2)); end
            3'd1: begin r = sa - sbv; v = (r > Mod / 2 - 1) || (r < -(Mod / 2)); end
            3'd2: r = longint'(a & b);
            3'd3: r = longint'(~b);
            3'd4: begin
                full  = longint'(a) * longint'(b);
                r     = full;
                v     = (full / Mod) != 0;
                nbusy = W;
            end
            3'd5: begin r = longint'(b) << sh; nbusy = sh; end
            3'd6: begin r = sbv >>> sh; nbusy = sh; end
            default: r = 0;
        endcase
        res = r[W-1:0];
        st  = {v, res[W-1], (res == '0)};
    endfunction

    // Waits for the ALU to be free, then drives one start cycle and queues the prediction.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int nbusy);
        exp_t e;
        int   guard = 0;
        while (bus.busy !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy still %b after %0d cycles", bus.busy, guard);
        end
        model(op, a, b, e.res, e.st, nbusy);
        e.done_cyc = cyc + 1 + nbusy;
        busy_start = cyc + 1;
        busy_end   = cyc + 1 + nbusy;
        sb.push_back(e);
        bus.start = 1'b1;
        bus.ALUop = op;
        bus.Ain   = a;
        bus.Bin   = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Drives start with random operands while the ALU is busy; all of it must be ignored.
    task automatic junk(input int n);
        for (int i = 0; i < n; i++) begin
            bus.start = 1'b1;
            bus.ALUop = 3'($urandom);
            bus.Ain   = W'($urandom);
            bus.Bin   = W'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    // Reset with a competing start request; outputs must be all zero after the first edge.
    task automatic do_reset(input int n);
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.ALUop = 3'd0;
        bus.Ain   = 16'd1;
        bus.Bin   = 16'd1;
        repeat (n) @(negedge clk);
        sb.delete();
        busy_start = 0;
        busy_end   = 0;
        held_res   = '0;
        held_st    = '0;
        chk("reset_out", bus.out, 64'd0);
        chk("reset_status", bus.status, 64'd0);
        chk("reset_busy", bus.busy, 64'd0);
        chk("reset_done", bus.done, 64'd0);
        bus.start = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            default: return W'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            chk("busy", bus.busy, (cyc >= busy_start && cyc < busy_end));
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 out=0x%0h with no op pending", bus.out);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out", bus.out, mon_e.res);
                    chk("status", bus.status, mon_e.st);
                    chk("done_cycle", cyc, mon_e.done_cyc);
                    held_res = mon_e.res;
                    held_st  = mon_e.st;
                end
            end else begin
                chk("out_hold", bus.out, held_res);
                chk("status_hold", bus.status, held_st);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d ops pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        bus.start = 1'b0;
        bus.ALUop = '0;
        bus.Ain   = '0;
        bus.Bin   = '0;
        @(negedge clk);
        do_reset(3);

        issue(3'd0, 16'd3, 16'd11, nb);  idle(2);
        issue(3'd1, 16'd5, 16'd2, nb);   idle(1);
        issue(3'd1, 16'd2, 16'd5, nb);   idle(1);
        issue(3'd0, 16'h7FFF, 16'd1, nb); idle(1);
        issue(3'd1, 16'd4, 16'd4, nb);   idle(1);
        issue(3'd2, 16'd7, 16'd9, nb);
        issue(3'd3, 16'd0, 16'd4, nb);
        issue(3'd0, 16'd100, 16'd23, nb); idle(2);

        issue(3'd4, 16'd300, 16'd7, nb);
        junk(4);
        issue(3'd4, 16'h0100, 16'h0100, nb);
        issue(3'd5, 16'd15, 16'd1, nb);
        junk(3);
        issue(3'd6, 16'd3, 16'h8000, nb);
        issue(3'd5, 16'd0, 16'h1234, nb);
        issue(3'd6, 16'd16, 16'h8765, nb);
        issue(3'd7, 16'hABCD, 16'h1234, nb);
        idle(2);

        // Abort a multiply part-way through; it must never complete.
        issue(3'd4, 16'd1234, 16'd99, nb);
        idle(4);
        do_reset(1);
        issue(3'd0, 16'd20, 16'd22, nb);
        idle(2);

        for (int i = 0; i < 300; i++) begin
            logic [2:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = 3'($urandom);
            a  = pick();
            b  = pick();
            if ((op == 3'd5 || op == 3'd6) && $urandom_range(0, 3) == 0) a[3:0] = 4'd0;
            issue(op, a, b, nb);
            if (nb > 1 && $urandom_range(0, 2) == 0) junk($urandom_range(1, (nb > 4) ? 4 : nb));
            idle($urandom_range(0, 2));
        end

        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d ops never completed", sb.size());
        end
        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
